// File: rtl/bin_pixel_packer.sv
// Binarises RGB pixels, packs PACK_W pixels per word into a FWFT output FIFO and counts foreground bits per frame.
// Optional `BIN_HYST_EN adds a HYST parameter and hysteresis on the threshold compare.
module bin_pixel_packer #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned PACK_W     = 16,
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned FIFO_DEPTH = 8
`ifdef BIN_HYST_EN
    ,
    parameter logic [DATA_W-1:0] HYST = DATA_W'(16)
`endif
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic              iDVAL,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic [DATA_W-1:0] iThreshold,
    input  logic [1:0]        iMode,
    input  logic              iInvert,
    input  logic              iClear,
    input  logic              iREADY,
    output logic [PACK_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oEOF,
    output logic [31:0]       oONES,
    output logic              oOVERFLOW,
    output logic [15:0]       oX,
    output logic [15:0]       oY
);

    localparam int unsigned PW = $clog2(PACK_W);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_W+1:0] luma_sum;
    logic [DATA_W-1:0] sel_int;
    logic              s1_val;
    logic [DATA_W-1:0] s1_int;
    logic [DATA_W-1:0] s1_thr;
    logic              s1_inv;

    logic [15:0]       x_q, y_q;
    logic [PW-1:0]     pos_q;
    logic [PACK_W-1:0] pack_q;
    logic [31:0]       ones_cnt, ones_q;
    logic              eof_q;
    logic              push_q;
    logic [PACK_W-1:0] word_q;

    logic [DATA_W-1:0] eff_thr;
    logic              raw_bit, pix_bit;
    logic              last_x, last_y, last_pos;
    logic [PACK_W-1:0] word_next;

    logic [PACK_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, do_push, do_pop, ovf_q;

    // Stage 1: intensity select
    always_comb begin
        luma_sum = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
        unique case (iMode)
            2'd0:    sel_int = iGreen;
            2'd1:    sel_int = iRed;
            2'd2:    sel_int = iBlue;
            default: sel_int = DATA_W'(luma_sum >> 2);
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) s1_val <= 1'b0;
        else      s1_val <= iDVAL;
    end

    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            s1_int <= sel_int;
            s1_thr <= iThreshold;
            s1_inv <= iInvert;
        end
    end

    // Stage 2: compare
`ifdef BIN_HYST_EN
    logic              prev_raw;
    logic [DATA_W:0]   thr_hi_sum;
    logic [DATA_W-1:0] thr_hi, thr_lo;

    always_comb begin
        thr_hi_sum = {1'b0, s1_thr} + {1'b0, HYST};
        thr_hi     = thr_hi_sum[DATA_W] ? '1 : thr_hi_sum[DATA_W-1:0];
        thr_lo     = (s1_thr < HYST) ? '0 : s1_thr - HYST;
        eff_thr    = prev_raw ? thr_lo : thr_hi;
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iSOF)              prev_raw <= 1'b0;
        else if (s1_val && last_x)     prev_raw <= 1'b0;
        else if (s1_val)               prev_raw <= raw_bit;
    end
`else
    always_comb eff_thr = s1_thr;
`endif

    always_comb begin
        raw_bit   = (s1_int > eff_thr);
        pix_bit   = raw_bit ^ s1_inv;
        last_x    = (x_q == 16'(IMG_W - 1));
        last_y    = (y_q == 16'(IMG_H - 1));
        last_pos  = (pos_q == PW'(PACK_W - 1));
        word_next = pack_q | (PACK_W'(pix_bit) << pos_q);
    end

    // Stage 2: pack, position and ones counting; completed words go through word_q into the FIFO
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q      <= '0;
            y_q      <= '0;
            pos_q    <= '0;
            pack_q   <= '0;
            ones_cnt <= '0;
            ones_q   <= '0;
            eof_q    <= 1'b0;
            push_q   <= 1'b0;
            word_q   <= '0;
        end else begin
            eof_q  <= 1'b0;
            push_q <= 1'b0;
            if (iSOF) begin
                x_q      <= '0;
                y_q      <= '0;
                pos_q    <= '0;
                pack_q   <= '0;
                ones_cnt <= '0;
            end else if (s1_val) begin
                ones_cnt <= ones_cnt + 32'(pix_bit);
                if (last_pos || last_x) begin
                    push_q <= 1'b1;
                    word_q <= word_next;
                    pack_q <= '0;
                    pos_q  <= '0;
                end else begin
                    pack_q <= word_next;
                    pos_q  <= pos_q + 1'b1;
                end
                if (last_x) begin
                    x_q <= '0;
                    if (last_y) begin
                        y_q      <= '0;
                        eof_q    <= 1'b1;
                        ones_q   <= ones_cnt + 32'(pix_bit);
                        ones_cnt <= '0;
                    end else begin
                        y_q <= y_q + 1'b1;
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    // Output FIFO, first-word-fall-through
    always_comb begin
        full    = (count == (AW + 1)'(FIFO_DEPTH));
        do_pop  = (count != '0) && iREADY;
        do_push = push_q && (!full || do_pop);
    end

    always_ff @(posedge iCLK) begin
        if (do_push) mem[wr_ptr] <= word_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_q && full && !do_pop) ovf_q <= 1'b1;
            else if (iClear)               ovf_q <= 1'b0;
        end
    end

    always_comb begin
        oDVAL     = (count != '0);
        oDATA     = oDVAL ? mem[rd_ptr] : '0;
        oEOF      = eof_q;
        oONES     = ones_q;
        oOVERFLOW = ovf_q;
        oX        = x_q;
        oY        = y_q;
    end

endmodule

// File: tb/tb_bin_pixel_packer.sv
// Scoreboard bench for bin_pixel_packer: pixel-level reference model feeds expected words and frame counts to a monitor.
module tb_bin_pixel_packer;

    localparam int DW = 12;
    localparam int PW = 16;
    localparam int IW = 20;
    localparam int IH = 3;
    localparam int FD = 4;

    logic          iCLK = 1'b0;
    logic          iRST, iSOF, iDVAL, iInvert, iClear, iREADY;
    logic [DW-1:0] iRed, iGreen, iBlue, iThreshold;
    logic [1:0]    iMode;
    logic [PW-1:0] oDATA;
    logic          oDVAL, oEOF, oOVERFLOW;
    logic [31:0]   oONES;
    logic [15:0]   oX, oY;

    bin_pixel_packer #(
        .DATA_W(DW), .PACK_W(PW), .IMG_W(IW), .IMG_H(IH), .FIFO_DEPTH(FD)
`ifdef BIN_HYST_EN
        , .HYST(12'd16)
`endif
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iThreshold(iThreshold),
        .iMode(iMode), .iInvert(iInvert), .iClear(iClear), .iREADY(iREADY),
        .oDATA(oDATA), .oDVAL(oDVAL), .oEOF(oEOF), .oONES(oONES),
        .oOVERFLOW(oOVERFLOW), .oX(oX), .oY(oY)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: positions, partial word, counts, scoreboard queues
    int            mx, my, mcnt, mones_last, mprev;
    logic [PW-1:0] mpack;
    bit            pend_v, pend_inv;
    int            pend_int, pend_thr;
    bit            hold_active, exp_ovf;
    int            held;
    int            thr_cfg = 100;
    logic [PW-1:0] exp_q[$];
    int            eof_q[$];

    function automatic int intensity(input int mode, input int r, input int g, input int b);
        case (mode)
            0:       return g;
            1:       return r;
            2:       return b;
            default: return (r + 2 * g + b) / 4;
        endcase
    endfunction

    task automatic push_word(input logic [PW-1:0] w);
        if (hold_active) begin
            if (held < FD) begin
                exp_q.push_back(w);
                held++;
            end else begin
                exp_ovf = 1'b1;
            end
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic commit();
        int thr, raw, b;
        thr = pend_thr;
`ifdef BIN_HYST_EN
        if (mprev != 0) thr = (pend_thr > 16) ? pend_thr - 16 : 0;
        else            thr = (pend_thr + 16 > 4095) ? 4095 : pend_thr + 16;
`endif
        raw = (pend_int > thr) ? 1 : 0;
        b   = raw ^ int'(pend_inv);
        if (b != 0) begin
            mpack[mx % PW] = 1'b1;
            mcnt++;
        end
        if ((mx % PW) == PW - 1 || mx == IW - 1) begin
            push_word(mpack);
            mpack = '0;
        end
        if (mx == IW - 1) begin
            mx    = 0;
            mprev = 0;
            if (my == IH - 1) begin
                my = 0;
                eof_q.push_back(mcnt);
                mones_last = mcnt;
                mcnt = 0;
            end else begin
                my++;
            end
        end else begin
            mx++;
            mprev = raw;
        end
    endtask

    task automatic step(input bit dval, input int r, input int g, input int b,
                        input int mode, input bit inv, input bit sof);
        iDVAL = dval; iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b);
        iMode = 2'(mode); iInvert = inv; iSOF = sof; iThreshold = DW'(thr_cfg);
        @(posedge iCLK); #1;
        if (sof) begin
            mx = 0; my = 0; mpack = '0; mcnt = 0; mprev = 0; pend_v = 1'b0;
        end else if (pend_v) begin
            commit();
        end
        pend_v = dval;
        if (dval) begin
            pend_int = intensity(mode, r, g, b);
            pend_thr = thr_cfg;
            pend_inv = inv;
        end
        iSOF = 1'b0; iClear = 1'b0;
        check("pos_x", oX, mx);
        check("pos_y", oY, my);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic rand_pix();
        step(1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset();
        iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        mx = 0; my = 0; mpack = '0; mcnt = 0; mprev = 0; mones_last = 0;
        pend_v = 1'b0; exp_ovf = 1'b0; hold_active = 1'b0; held = 0;
        exp_q.delete(); eof_q.delete();
        check("rst_dval", oDVAL, 0);
        check("rst_eof", oEOF, 0);
        check("rst_ovf", oOVERFLOW, 0);
        check("rst_x", oX, 0);
        check("rst_y", oY, 0);
        check("rst_ones", oONES, 0);
        check("rst_data", oDATA, 0);
    endtask

    task automatic wait_drain();
        iREADY = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || pend_v); i++) idle();
        check("drain_done", exp_q.size() + int'(pend_v), 0);
        idle();
        check("empty_after_drain", oDVAL, 0);
    endtask

    // Monitor: pops expected words on each accepted output and frame counts on each oEOF
    initial begin
        logic [PW-1:0] ew;
        int eo;
        forever begin
            @(negedge iCLK);
            if (oDVAL && iREADY) begin
                if (exp_q.size() == 0) check("word_unexpected", oDATA, 32'hdead);
                else begin
                    ew = exp_q.pop_front();
                    check("word", oDATA, ew);
                end
            end
            if (oEOF) begin
                if (eof_q.size() == 0) check("eof_unexpected", 1, 0);
                else begin
                    eo = eof_q.pop_front();
                    check("frame_ones", oONES, eo);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        bit last_low;
        iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
        iThreshold = DW'(100); iMode = '0; iInvert = 1'b0; iClear = 1'b0; iREADY = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;
        do_reset();

        // Alternating 200/50 line: first word 5555, visible two edges after pixel 15
        for (int x = 0; x < IW; x++) begin
            step(1'b1, 0, (x % 2 == 0) ? 200 : 50, 0, 0, 1'b0, 1'b0);
            if (x == 16) check("lat_early", oDVAL, 0);
            if (x == 17) begin
                check("lat_dval", oDVAL, 1);
                check("lat_word", oDATA, 16'h5555);
            end
        end

        // Mode/invert/equality corner pixels, then the rest of the line random
        step(1'b1, 100, 100, 104, 3, 1'b0, 1'b0);
        step(1'b1, 100, 100, 104, 3, 1'b1, 1'b0);
        step(1'b1, 100, 0, 0, 1, 1'b0, 1'b0);
        step(1'b1, 0, 0, 100, 2, 1'b1, 1'b0);
        for (int x = 4; x < IW; x++) rand_pix();

        // Padding frame: all white, new frame via iSOF on the first pixel
        for (int i = 0; i < IW * IH; i++) step(1'b1, 4095, 4095, 4095, 0, 1'b0, i == 0);
        repeat (3) idle();
        check("pad_ones", oONES, IW * IH);
        wait_drain();

        // Randomized traffic with light backpressure and occasional frame restarts
        last_low = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            iREADY = last_low ? 1'b1 : ($urandom_range(0, 3) != 0);
            last_low = !iREADY;
            thr_cfg = $urandom_range(0, 4095);
            if ($urandom_range(0, 9) < 3) idle();
            else step(1'b1, $urandom_range(0, 4095), $urandom_range(0, 4095),
                      $urandom_range(0, 4095), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), $urandom_range(0, 299) == 0);
        end
        thr_cfg = 100;
        wait_drain();
        check("no_ovf_random", oOVERFLOW, 0);

        // iSOF mid-line: position restarts, oONES untouched
        for (int i = 0; i < 100 && mx != 10; i++) rand_pix();
        step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
        check("sof_x", oX, 0);
        check("sof_ones", oONES, mones_last);
        for (int x = 0; x < IW; x++) step(1'b1, 0, (x % 3 == 0) ? 4095 : 0, 0, 0, 1'b0, 1'b0);
        wait_drain();

        // Overflow: no pops while six words arrive; first FD retained
        iREADY = 1'b0;
        hold_active = 1'b1;
        held = 0;
        for (int i = 0; i < IW * IH; i++) rand_pix();
        repeat (4) idle();
        check("ovf_set", oOVERFLOW, exp_ovf);
        check("ovf_held_dval", oDVAL, 1);
        hold_active = 1'b0;
        wait_drain();
        check("ovf_sticky", oOVERFLOW, 1);
        iClear = 1'b1;
        idle();
        check("ovf_cleared", oOVERFLOW, 0);

        // Reset mid-word
        for (int i = 0; i < 5; i++) rand_pix();
        do_reset();
        for (int i = 0; i < IW; i++) rand_pix();
        wait_drain();
        check("eof_all_seen", eof_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_pixel_packer.md
Name: bin_pixel_packer

Overview:
- Sits between RAW2RGB and the SDRAM write FIFO.
- Reduces each RGB pixel to one binary bit using a selectable intensity source, a threshold and an optional inversion.
- Packs PACK_W consecutive pixels of a line into one SDRAM word, so memory is no longer spent on one pixel per 16-bit word.
- Buffers packed words in a small FIFO with a valid/ready output, and reports per-frame foreground pixel counts to the HPS.

Parameters:
- DATA_W, 12: width of input colour channels and threshold.
- PACK_W, 16: pixels per output word; legal range 2..32.
- IMG_W, 640: pixels per line.
- IMG_H, 480: lines per frame.
- FIFO_DEPTH, 8: output FIFO depth in words; power of two, at least 2.

Ports:
- iCLK, in, 1: clock (CCD_PIXCLK domain).
- iRST, in, 1: synchronous, active-high reset.
- iSOF, in, 1: start-of-frame pulse; clears position and count state.
- iDVAL, in, 1: input pixel valid.
- iRed, in, DATA_W: red channel.
- iGreen, in, DATA_W: green channel.
- iBlue, in, DATA_W: blue channel.
- iThreshold, in, DATA_W: binarisation threshold.
- iMode, in, 2: intensity source. 0 = G, 1 = R, 2 = B, 3 = luma (R+2G+B)>>2.
- iInvert, in, 1: invert output bit.
- iClear, in, 1: clears oOVERFLOW.
- iREADY, in, 1: downstream accepts oDATA.
- oDATA, out, PACK_W: packed word; pixel x occupies bit (x mod PACK_W), LSB first.
- oDVAL, out, 1: oDATA valid.
- oEOF, out, 1: one-cycle pulse after the last pixel of a frame.
- oONES, out, 32: count of 1-bits in the last completed frame.
- oOVERFLOW, out, 1: sticky flag; FIFO was full on a push.
- oX, out, 16: current x position.
- oY, out, 16: current y position.

Behaviour:
- Reset, while iRST=1 at a rising edge:
  - Outputs: oDVAL, oEOF, oOVERFLOW, oX, oY = 0; oONES = 0; oDATA = 0.
  - Internal: FIFO emptied, pack register and pipeline valids cleared.
  - Reset mid-word discards the partial word and everything in the FIFO.
- Stage 1 (1 cycle): intensity register.
  - The selected channel is registered when iDVAL=1.
  - Luma is computed at DATA_W+2 bits, then shifted right by 2, with no saturation needed.
  - iMode and iInvert are sampled per pixel.
- Stage 2: compare and pack.
  - bit = (intensity > iThreshold) XOR iInvert. Equality gives 0 before inversion.
  - The bit is written into the pack register at position x mod PACK_W.
  - x increments. At x = IMG_W-1 the next x is 0 and y increments. At the last pixel of line IMG_H-1, y wraps to 0 and oEOF pulses in the following cycle.
- Word push: the word is pushed to the FIFO when the pack position reaches PACK_W-1 or at end of line.
  - At end of line, unfilled upper bits are 0.
  - Words per line = ceil(IMG_W/PACK_W). For 640/16 that is 40.
  - The pack register is cleared after each push.
- Latency, with FIFO empty and iREADY=1: the last pixel of a word is sampled at edge N; the word is on oDATA with oDVAL=1 after edge N+2.
- FIFO behaviour:
  - First-word-fall-through. A word is popped on an edge where oDVAL=1 and iREADY=1.
  - Simultaneous push and pop when full is allowed and loses no data.
  - A push when full without a pop drops the new word and sets oOVERFLOW.
  - oOVERFLOW stays set until iClear or reset. If iClear and an overflow occur in the same cycle, the set wins.
- oONES:
  - An internal counter increments per 1-bit; padding bits are not counted.
  - At frame end the counter transfers to oONES in the same cycle oEOF asserts, and the counter restarts at 0. If a 1-bit arrives in that cycle, the counter restarts at 1.
- iSOF:
  - Clears x, y, the pack register and the internal ones counter on the next edge.
  - Pixels already in Stage 1 are discarded. The FIFO and oONES are kept.
  - If iSOF and iDVAL occur together, the pixel is treated as x=0, y=0 of the new frame.
- Pixels with iDVAL=0 do not advance any state.

Optional Feature:
- Macro: BIN_HYST_EN.
- When defined:
  - Adds parameter HYST, default 16, of width DATA_W.
  - The compare uses iThreshold+HYST if the previous raw bit on the same line was 0, and iThreshold-HYST if it was 1.
  - Both bounds saturate at 0 and at 2^DATA_W-1.
  - The previous-bit state resets to 0 at line start and on iSOF.
- When undefined: the single threshold compare above applies; HYST is absent.

Test Plan:
- Setup for all scenarios unless stated: IMG_W=640, PACK_W=16, iMode=0, iThreshold=100.
- Binarisation and packing: iGreen alternates 200/50 from x=0 -> first word 16'h5555, oDVAL two edges after the pixel at x=15, and 40 words per line.
- Padding: IMG_W=20, PACK_W=16, all pixels iGreen=4095 -> per line the words are 16'hFFFF then 16'h000F; oONES=20*IMG_H at oEOF.
- Modes and invert:
  - iMode=3 with R=100, G=100, B=104: luma 101 -> bit 1.
  - Same stimulus with iInvert=1 -> bit 0.
  - iMode=1 with R=100: equal to threshold -> bit 0.
- Backpressure and overflow: FIFO_DEPTH=4, iREADY=0 for 5 full words -> 4 words retained and oOVERFLOW=1. Then iREADY=1 -> 4 words drain in order. iClear -> oOVERFLOW=0.
- Frame boundary and reset:
  - iSOF at x=300 mid-line -> next pixel packs at bit 0 with oX=0; oONES is unchanged.
  - iRST mid-word -> oDVAL=0 on the next edge and all outputs at their reset values.
- Hysteresis (BIN_HYST_EN, HYST=16): line sequence 110, 120, 90, 80 -> bits 0, 1, 1, 0.
